// File: rtl/mbledhesi_serial_imm.sv
// Digit-serial add/subtract unit for register-immediate ALU ops.
// Each RUN cycle adds DIGIT bits of rs and immediate plus a registered carry
// and shifts the partial result in from the MSB side. After WIDTH/DIGIT
// cycles the result is published to the output registers.
module mbledhesi_serial_imm #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] immediate,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("mbledhesi_serial_imm: DIGIT must divide WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q, ovf_q, zero_q;

    logic [DIGIT-1:0]  dsum;
    logic [DIGIT:0]    c;
    logic [WIDTH-1:0]  res_next;
    logic              last;
    logic              accept;

    // Ripple chain of DIGIT full-adder cells over the operand LSBs
    always_comb begin
        c[0] = carry_q;
        dsum = '0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // New digit enters at the MSB side so the result ends LSB-aligned
    assign res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    assign last     = (cnt_q == CW'(N - 1));
    assign ready    = (state_q != StRun);
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign accept   = ready && start;

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

    // Next-state logic: IDLE -> RUN -> DONE, DONE may restart directly
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, digit shifting and result publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (accept) begin
            // Subtract as rs + ~imm + 1
            a_q     <= rs;
            b_q     <= sub ? ~immediate : immediate;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (state_q == StRun) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            res_q   <= res_next;
            carry_q <= c[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                // On the final digit, c[DIGIT-1] is the carry into the MSB
                sum_q  <= res_next;
                cout_q <= c[DIGIT];
                ovf_q  <= c[DIGIT-1] ^ c[DIGIT];
                zero_q <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_mbledhesi_serial_imm.sv
// Directed self-checking bench: one DIGIT=1 and one DIGIT=4 instance.
module tb_mbledhesi_serial_imm;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // DIGIT=1 instance signals
    logic        start1, sub1, cin1;
    logic [15:0] rs1, imm1;
    logic        ready1, busy1, done1, cout1, ovf1, zero1;
    logic [15:0] sum1;

    // DIGIT=4 instance signals
    logic        start4, sub4, cin4;
    logic [15:0] rs4, imm4;
    logic        ready4, busy4, done4, cout4, ovf4, zero4;
    logic [15:0] sum4;

    mbledhesi_serial_imm #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .rs(rs1),
        .immediate(imm1), .cin(cin1), .ready(ready1), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1), .overflow(ovf1), .zero(zero1)
    );

    mbledhesi_serial_imm #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .rs(rs4),
        .immediate(imm4), .cin(cin4), .ready(ready4), .busy(busy4), .done(done4),
        .sum(sum4), .cout(cout4), .overflow(ovf4), .zero(zero4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op from the current negedge and wait for done. lat counts
    // negedges after the start edge up to the one where done is seen.
    // noise: assert start with junk operands during the first RUN cycles.
    // hold: while running, check that sum still shows hold_val.
    task automatic do_op(input bit sel4, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic ci, input bit noise,
                         input bit hold, input logic [15:0] hold_val,
                         output int lat, output int busy_cyc);
        bit seen;
        if (sel4) begin
            start4 = 1'b1; rs4 = a; imm4 = b; sub4 = s; cin4 = ci;
        end else begin
            start1 = 1'b1; rs1 = a; imm1 = b; sub1 = s; cin1 = ci;
        end
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        rs1 = 16'($urandom); imm1 = 16'($urandom); sub1 = 1'($urandom); cin1 = 1'($urandom);
        rs4 = 16'($urandom); imm4 = 16'($urandom); sub4 = 1'($urandom); cin4 = 1'($urandom);
        lat = 0; busy_cyc = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (sel4 ? busy4 : busy1) busy_cyc++;
            if (sel4 ? done4 : done1) seen = 1'b1;
            if (hold && lat == 8) check_eq("hold_during_run", 32'(sum1), 32'(hold_val));
            if (noise) begin
                start1 = (lat <= 10);
                rs1 = 16'($urandom); imm1 = 16'($urandom); sub1 = 1'($urandom);
            end
        end
        start1 = 1'b0;
        if (!seen) check_eq("done_timeout", 32'(lat), 32'd0);
    endtask

    int lat, bcyc, dcnt;

    initial begin
        rst_n = 1'b0;
        start1 = 0; sub1 = 0; cin1 = 0; rs1 = 0; imm1 = 0;
        start4 = 0; sub4 = 0; cin4 = 0; rs4 = 0; imm4 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_ready", 32'(ready1), 32'd1);
        check_eq("rst_busy",  32'(busy1),  32'd0);
        check_eq("rst_done",  32'(done1),  32'd0);
        check_eq("rst_sum",   32'(sum1),   32'd0);
        check_eq("rst_flags", {29'd0, cout1, ovf1, zero1}, 32'd0);
        check_eq("rst_d4",    {sum4, 13'd0, ready4, busy4, done4}, {16'd0, 13'd0, 3'b100});

        // 1: 0x7FFF + 1 -> signed overflow
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, lat, bcyc);
        check_eq("t1_latency", 32'(lat), 32'd17);
        check_eq("t1_busy_cycles", 32'(bcyc), 32'd16);
        check_eq("t1_sum", 32'(sum1), 32'h8000);
        check_eq("t1_flags", {29'd0, cout1, ovf1, zero1}, 32'b010);
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(done1), 32'd0);

        // 2: 0xFFFF + 1 wraps to zero with carry out
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, lat, bcyc);
        check_eq("t2_sum", 32'(sum1), 32'h0000);
        check_eq("t2_flags", {29'd0, cout1, ovf1, zero1}, 32'b101);
        @(negedge clk);

        // 3: 5 - 7 with cin=1 ignored -> borrow, no overflow
        do_op(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, lat, bcyc);
        check_eq("t3_sum", 32'(sum1), 32'hFFFE);
        check_eq("t3_flags", {29'd0, cout1, ovf1, zero1}, 32'b000);
        @(negedge clk);

        // 4: DIGIT=4, 0x1234 + 0x0FF1 + 1
        do_op(1'b1, 16'h1234, 16'h0FF1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, lat, bcyc);
        check_eq("t4_latency", 32'(lat), 32'd5);
        check_eq("t4_busy_cycles", 32'(bcyc), 32'd4);
        check_eq("t4_sum", 32'(sum4), 32'h2226);
        check_eq("t4_flags", {29'd0, cout4, ovf4, zero4}, 32'b000);
        @(negedge clk);
        check_eq("t4_done_pulse", 32'(done4), 32'd0);

        // 5: starts during RUN are ignored, then back-to-back start in DONE
        do_op(1'b0, 16'h1000, 16'h0234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, lat, bcyc);
        check_eq("t5_noisy_sum", 32'(sum1), 32'h1234);
        check_eq("t5_noisy_latency", 32'(lat), 32'd17);
        do_op(1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, lat, bcyc);
        check_eq("t5_b2b_latency", 32'(lat), 32'd17);
        check_eq("t5_b2b_sum", 32'(sum1), 32'h0007);
        @(negedge clk);

        // 6: reset in the middle of RUN aborts the op
        start1 = 1'b1; rs1 = 16'h1111; imm1 = 16'h0001; sub1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t6_busy_before_rst", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_sum", 32'(sum1), 32'd0);
        check_eq("t6_rst_state", {29'd0, ready1, busy1, done1}, 32'b100);
        check_eq("t6_rst_flags", {29'd0, cout1, ovf1, zero1}, 32'b000);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done1) dcnt++;
        end
        check_eq("t6_no_done", 32'(dcnt), 32'd0);
        do_op(1'b0, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, lat, bcyc);
        check_eq("t6_after_sum", 32'(sum1), 32'h0030);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
